// File: rtl/mandelbrot_pixel_writer.sv
// Buffers completed Mandelbrot pixels in a small FIFO, maps iteration count to RGB332
// and writes each pixel into VGA memory over a single-beat we/ack handshake.
module mandelbrot_pixel_writer #(
   parameter int unsigned H_RES      = 640,
   parameter int unsigned V_RES      = 480,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        fin_val,
   input  logic [9:0]  single_x,
   input  logic [9:0]  single_y,
   input  logic [10:0] single_num_iter,
   input  logic [31:0] max_iter,
   output logic [18:0] mem_addr,
   output logic [7:0]  mem_data,
   output logic        mem_we,
   input  logic        mem_ack,
   output logic        stall,
   output logic        overflow,
   output logic        frame_done,
   output logic [18:0] pixel_count
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [18:0] FRAME_LAST = 19'(H_RES * V_RES - 1);

   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [10:0] n;
   } entry_t;

   typedef enum logic {ST_IDLE, ST_WRITE} state_t;

   state_t         r_state;
   entry_t         r_fifo [FIFO_DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic [18:0]    r_mem_addr;
   logic [7:0]     r_mem_data;
   logic           r_mem_we;
   logic           r_stall;
   logic           r_overflow;
   logic           r_frame_done;
   logic [18:0]    r_pixel_count;

   logic           w_in_range;
   logic           w_full;
   logic           w_pop;
   logic           w_push;
   logic           w_drop;
   logic [CW-1:0]  w_count_nxt;
   entry_t         w_head;
   logic [18:0]    w_addr;
   logic [7:0]     w_colour;

   function automatic logic [7:0] f_colour(input logic [10:0] n_in, input logic [31:0] lim);
      logic [31:0] n;
      n = {21'd0, n_in};
      if      (n >= lim)       return 8'h00;
      else if (n >= (lim >> 1)) return 8'hE0;
      else if (n >= (lim >> 2)) return 8'hEC;
      else if (n >= (lim >> 3)) return 8'hFC;
      else if (n >= (lim >> 4)) return 8'h1C;
      else if (n >= (lim >> 5)) return 8'h1F;
      else if (n >= (lim >> 6)) return 8'h03;
      else if (n >= (lim >> 7)) return 8'h23;
      else                      return 8'h49;
   endfunction

   always_comb begin
      w_in_range  = fin_val && !frame_start &&
                    (32'(single_x) < H_RES) && (32'(single_y) < V_RES);
      w_full      = (r_count == CW'(FIFO_DEPTH));
      w_pop       = (r_state == ST_IDLE) && (r_count != '0) && !frame_start;
      // A full FIFO still accepts a result when the head leaves on the same edge.
      w_push      = w_in_range && (!w_full || w_pop);
      w_drop      = w_in_range && w_full && !w_pop;
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
      w_head      = r_fifo[r_rd_ptr];
      w_addr      = 19'(w_head.y) * 19'(H_RES) + 19'(w_head.x);
      w_colour    = f_colour(w_head.n, max_iter);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_mem_addr    <= '0;
         r_mem_data    <= '0;
         r_mem_we      <= 1'b0;
         r_stall       <= 1'b0;
         r_overflow    <= 1'b0;
         r_frame_done  <= 1'b0;
         r_pixel_count <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      end else if (frame_start) begin
         r_state       <= ST_IDLE;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_mem_we      <= 1'b0;
         r_stall       <= 1'b0;
         r_overflow    <= 1'b0;
         r_frame_done  <= 1'b0;
         r_pixel_count <= '0;
      end else begin
         r_frame_done <= 1'b0;
         if (w_push) begin
            r_fifo[r_wr_ptr] <= '{x: single_x, y: single_y, n: single_num_iter};
            r_wr_ptr         <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         r_stall <= (w_count_nxt >= CW'(FIFO_DEPTH - 1));
         if (w_drop) r_overflow <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_mem_addr <= w_addr;
                  r_mem_data <= w_colour;
                  r_mem_we   <= 1'b1;
                  r_state    <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (mem_ack) begin
                  r_mem_we <= 1'b0;
                  r_state  <= ST_IDLE;
                  if (r_pixel_count == FRAME_LAST) begin
                     r_pixel_count <= '0;
                     r_frame_done  <= 1'b1;
                  end else begin
                     r_pixel_count <= r_pixel_count + 19'd1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign mem_addr    = r_mem_addr;
   assign mem_data    = r_mem_data;
   assign mem_we      = r_mem_we;
   assign stall       = r_stall;
   assign overflow    = r_overflow;
   assign frame_done  = r_frame_done;
   assign pixel_count = r_pixel_count;

endmodule
